pipeline_fetch_stage: RTL

PIPELINE_FETCH_STAGE -- requirements
Module: pipeline_fetch_stage

---
 rtl/pipeline_fetch_stage.sv | 86 ++++++++
 1 files changed

// File: rtl/pipeline_fetch_stage.sv
// pipeline_fetch_stage: PC register, RUN/HALT FSM and IF/ID latch; FETCH_PERF_COUNT_EN adds fetch/stall counters
module pipeline_fetch_stage #(
    parameter logic [63:0] RESET_PC     = 64'h0,
    parameter int          HALT_ON_ZERO = 1
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        stall,
    input  logic        flush,
    input  logic        branch_taken,
    input  logic [63:0] branch_target,
    output logic [63:0] read_address,
    input  logic [31:0] instruction,
    output logic [63:0] if_id_pc,
    output logic [31:0] if_id_instruction,
    output logic        if_id_valid,
    output logic        halted
`ifdef FETCH_PERF_COUNT_EN
    ,
    output logic [31:0] fetch_count,
    output logic [31:0] stall_count
`endif
);
    localparam logic [0:0] RUN  = 1'b0;
    localparam logic [0:0] HALT = 1'b1;

    logic [63:0] pc;
    logic [0:0]  state;
    logic        run, hold, advance, zero_halt, latch;

    assign read_address = pc;
    assign halted       = state == HALT;

    // Per-edge action: branch beats stall beats advance; a zero word under HALT_ON_ZERO parks the FSM
    always_comb begin
        run       = state == RUN;
        hold      = run && stall && !branch_taken;
        advance   = run && !stall && !branch_taken;
        zero_halt = advance && (HALT_ON_ZERO != 0) && (instruction == 32'h0);
        latch     = advance && !zero_halt && !flush;
    end

    // PC, FSM and IF/ID; bubbles clear valid and instruction but never touch if_id_pc
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pc                <= RESET_PC;
            state             <= RUN;
            if_id_pc          <= 64'h0;
            if_id_instruction <= 32'h0;
            if_id_valid       <= 1'b0;
        end else if (branch_taken) begin
            pc                <= {branch_target[63:2], 2'b00};
            state             <= RUN;
            if_id_instruction <= 32'h0;
            if_id_valid       <= 1'b0;
        end else if (run) begin
            if (advance && !zero_halt)
                pc <= pc + 64'd4;
            if (zero_halt)
                state <= HALT;
            if (latch) begin
                if_id_pc          <= pc;
                if_id_instruction <= instruction;
                if_id_valid       <= 1'b1;
            end else if (flush || zero_halt) begin
                if_id_instruction <= 32'h0;
                if_id_valid       <= 1'b0;
            end
        end
    end

`ifdef FETCH_PERF_COUNT_EN
    // Counters wrap naturally at 2^32
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            fetch_count <= 32'h0;
            stall_count <= 32'h0;
        end else begin
            if (latch)
                fetch_count <= fetch_count + 32'd1;
            if (hold)
                stall_count <= stall_count + 32'd1;
        end
    end
`endif
endmodule
